// File: rtl/instr_fetch_unit_pkg.sv
// Shared constants and types for the instruction fetch control stage.
package instr_fetch_unit_pkg;

    // Fetch FSM state encodings (2 bits).
    typedef enum logic [1:0] {
        ST_ADVANCE = 2'd0,
        ST_FETCH   = 2'd1,
        ST_HOLD    = 2'd2,
        ST_DRAIN   = 2'd3
    } fetch_state_e;

    // Byte size of one instruction; the sequential PC step.
    localparam int unsigned INSTR_BYTES = 4;

    // PC value after reset: one step before address zero, so the first
    // ADVANCE lands the first fetch on 0x0000_0000.
    localparam logic [31:0] RESET_PC = 32'hFFFF_FFFC;

endpackage : instr_fetch_unit_pkg

// File: rtl/instr_fetch_unit.sv
// Fetch control stage: drives the next PC value, issues one instruction
// memory request at a time and buffers the fetched word for decode.
// Branch/jump redirects squash the buffered or in-flight instruction; an
// un-acked request is kept alive in DRAIN so memory sees a clean handshake.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] instrAddr,
    output logic [ADDR_W-1:0] nextInstrAddr,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirectAddr,
    output logic              imemReq,
    output logic [ADDR_W-1:0] imemAddr,
    input  logic              imemAck,
    input  logic [DATA_W-1:0] imemData,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instrPC,
    output logic              instrValid,
    input  logic              instrReady
);

    fetch_state_e      state_q;
    logic [DATA_W-1:0] instr_q;
    logic [ADDR_W-1:0] instr_pc_q;
    logic              instr_valid_q;
    logic [ADDR_W-1:0] drain_addr_q;

    logic [ADDR_W-1:0] redirect_target_s;
    logic [ADDR_W-1:0] pc_plus_step_s;

    assign redirect_target_s = {redirectAddr[ADDR_W-1:2], 2'b00};
    assign pc_plus_step_s    = instrAddr + ADDR_W'(INSTR_BYTES);

    // Next PC: redirect target wins, ADVANCE steps by one instruction, else hold.
    always_comb begin
        nextInstrAddr = instrAddr;
        if (redirect) begin
            nextInstrAddr = redirect_target_s;
        end else if (state_q == ST_ADVANCE) begin
            nextInstrAddr = pc_plus_step_s;
        end else begin
            nextInstrAddr = instrAddr;
        end
    end

    // Request outputs are pure decodes of the state register; in FETCH the
    // address is the held PC, in DRAIN the address captured at the redirect.
    assign imemReq  = (state_q == ST_FETCH) || (state_q == ST_DRAIN);
    assign imemAddr = (state_q == ST_DRAIN) ? drain_addr_q : instrAddr;

    assign instr      = instr_q;
    assign instrPC    = instr_pc_q;
    assign instrValid = instr_valid_q;

    // Fetch FSM together with the decode-side instruction buffer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_ADVANCE;
            instr_q       <= '0;
            instr_pc_q    <= '0;
            instr_valid_q <= 1'b0;
            drain_addr_q  <= '0;
        end else begin
            case (state_q)
                ST_ADVANCE: begin
                    // A redirect here only suppresses the step (handled on
                    // nextInstrAddr); the buffer is already empty.
                    state_q       <= ST_FETCH;
                    instr_valid_q <= 1'b0;
                end
                ST_FETCH: begin
                    if (redirect) begin
                        instr_valid_q <= 1'b0;
                        if (imemAck) begin
                            // Stale data arrives with the redirect: drop it.
                            state_q <= ST_FETCH;
                        end else begin
                            // Keep the old request alive until memory acks.
                            state_q      <= ST_DRAIN;
                            drain_addr_q <= instrAddr;
                        end
                    end else if (imemAck) begin
                        instr_q       <= imemData;
                        instr_pc_q    <= instrAddr;
                        instr_valid_q <= 1'b1;
                        state_q       <= ST_HOLD;
                    end else begin
                        state_q <= ST_FETCH;
                    end
                end
                ST_HOLD: begin
                    if (redirect) begin
                        // Dropped even if decode accepts it in this cycle.
                        instr_valid_q <= 1'b0;
                        state_q       <= ST_FETCH;
                    end else if (instrReady) begin
                        instr_valid_q <= 1'b0;
                        state_q       <= ST_ADVANCE;
                    end else begin
                        state_q <= ST_HOLD;
                    end
                end
                ST_DRAIN: begin
                    instr_valid_q <= 1'b0;
                    if (imemAck) begin
                        state_q <= ST_FETCH;
                    end else begin
                        state_q <= ST_DRAIN;
                    end
                end
                default: begin
                    state_q       <= ST_ADVANCE;
                    instr_valid_q <= 1'b0;
                end
            endcase
        end
    end

endmodule : instr_fetch_unit

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Fetch control stage that sits directly upstream of the program counter: it computes `nextInstrAddr` for the PC and fetches the instruction at the current `instrAddr` over a req/ack instruction-memory handshake. It presents the instruction to decode with a valid/ready handshake. It also applies branch/jump redirects from execute, squashing any in-flight or buffered instruction. Multicycle, one instruction in flight.

## Interface
- `ADDR_W`, 32: address width.
- `DATA_W`, 32: instruction width.
- `clk`  in  1: clock.
- `rst`  in  1: synchronous reset, active-high.
- `instrAddr`  in  ADDR_W: current PC value.
- `nextInstrAddr`  out  ADDR_W: PC value loaded at the next clock edge (combinational).
- `redirect`  in  1: branch/jump taken this cycle.
- `redirectAddr`  in  ADDR_W: target address; bits [1:0] are ignored and forced to 0.
- `imemReq`  out  1: memory request, held until `imemAck`.
- `imemAddr`  out  ADDR_W: request address, stable while `imemReq`=1.
- `imemAck`  in  1: single-cycle acknowledge; `imemData` is valid in the same cycle.
- `imemData`  in  DATA_W: fetched word.
- `instr`  out  DATA_W: instruction to decode (registered).
- `instrPC`  out  ADDR_W: address of `instr` (registered).
- `instrValid`  out  1: `instr` is valid.
- `instrReady`  in  1: decode accepts `instr`.

## Operation
- **FSM states:** ADVANCE, FETCH, HOLD, DRAIN. Reset state is ADVANCE.
- **ADVANCE:**
  - `nextInstrAddr` = `instrAddr`+4, modulo 2^32 (0xFFFF_FFFC wraps to 0x0000_0000).
  - Next state is FETCH.
  - After reset the PC holds 0xFFFF_FFFC, so the first fetch is at 0x0000_0000.
- **FETCH:**
  - `imemReq`=1, `imemAddr`=`instrAddr`, `nextInstrAddr`=`instrAddr` (PC held).
  - On `imemAck`: `instr`←`imemData`, `instrPC`←`instrAddr`, `instrValid`←1, then go to HOLD.
- **HOLD:**
  - `nextInstrAddr`=`instrAddr`, `imemReq`=0.
  - On `instrReady`: `instrValid`←0, then go to ADVANCE.
- **DRAIN:**
  - `imemReq`=1, `imemAddr`=`drainAddr` (internal register).
  - `nextInstrAddr`=`instrAddr`.
  - On `imemAck`: data discarded, then go to FETCH.
- **Redirect** overrides every state: `nextInstrAddr`={`redirectAddr`[31:2],2'b00}, and `instrValid`←0 at the next edge.
  - ADVANCE → FETCH. The +4 step is suppressed.
  - FETCH with `imemAck`=1 → FETCH. The acked data is discarded; `instr`/`instrPC` are unchanged.
  - FETCH with `imemAck`=0 → DRAIN. `drainAddr`←`instrAddr`; the request is kept alive at the old address.
  - HOLD → FETCH. A buffered instruction is dropped even if `instrReady`=1 in the same cycle.
  - DRAIN with `imemAck`=1 → FETCH. DRAIN with `imemAck`=0 stays in DRAIN; the new target is applied to the PC.
- **Reset precedence:** `rst` dominates `redirect` and `imemAck`. A mid-request reset abandons the request, and instruction memory is reset by the same `rst`.

## Timing
- **Reset values:** `imemReq`=0, `instrValid`=0, `instr`=0, `instrPC`=0, `drainAddr`=0, state=ADVANCE.
- `nextInstrAddr` and `imemAddr` are don't-care while `rst`=1.
- **Latency with ack in the first FETCH cycle:**
  - ADVANCE (1 cycle) + FETCH (1 cycle) → `instrValid` rises at the edge ending FETCH.
  - Best-case throughput is one instruction per 3 cycles.
- Each extra memory wait cycle adds 1 cycle. Each `instrReady`=0 cycle in HOLD adds 1 cycle.
- **Handshakes:**
  - `imemReq`/`imemAddr` never change between assertion and ack.
  - `instr`/`instrPC` never change while `instrValid`=1.
- Redirect-to-first-request latency is 1 cycle (FETCH at the target), or 1 + remaining ack wait if it passes through DRAIN.

## Structure
- Shared constants header holds: state encodings (2 bits), `INSTR_BYTES`=4, reset-PC constant 0xFFFF_FFFC (used by bench checks).
- Single module, no sub-module. The +4 adder and next-address mux are inline.

## Test plan
- **Reset then 1-cycle ack memory, `instrReady`=1 always:** `imemAddr` sequence 0x0, 0x4, 0x8. `instrValid` pulses every 3rd cycle with the matching `instrPC`.
- **`imemAck` delayed 3 cycles at 0x4:** `imemReq` and `imemAddr`=0x4 stay stable for 4 cycles. The PC holds at 0x4. `instr` equals the word at 0x4.
- **`instrReady`=0 for 5 cycles in HOLD:** `instr`/`instrPC` stay constant. No new `imemReq`. The PC holds.
- **Redirect to 0x103 during an un-acked FETCH at 0x8:**
  - State goes to DRAIN and `imemAddr` stays 0x8 until ack.
  - The 0x8 data is never presented.
  - The next request is at 0x100.
- **Redirect in HOLD together with `instrReady`:** `instrValid` falls, the next fetch is at the target, and no duplicate issue occurs.
- **PC at 0xFFFF_FFFC:** the next request wraps to 0x0000_0000. Asserting `rst` mid-request forces all outputs to reset values within 1 edge.
